// File: rtl/text_fetch_sched_if.sv
// Bundle of the text-mode fetch scheduler's line timing, text RAM, font ROM,
// line buffer and CPU write port signals.
interface text_fetch_sched_if #(
   parameter int CORDW = 11,
   parameter int COLS  = 64,
   parameter int ROWS  = 18
);
   localparam int TADDRW = $clog2(COLS * ROWS);
   localparam int CADDRW = $clog2(COLS);

   logic                     line;
   logic signed [CORDW-1:0]  sy;
   logic [TADDRW-1:0]        tram_addr;
   logic                     tram_rd;
   logic                     tram_wr;
   logic [7:0]               tram_wdata;
   logic [7:0]               tram_rdata;
   logic [7:0]               font_char;
   logic [2:0]               font_row;
   logic [7:0]               font_bits;
   logic                     lb_we;
   logic                     lb_bank;
   logic [CADDRW-1:0]        lb_addr;
   logic [7:0]               lb_data;
   logic                     disp_bank;
   // CPU handshake: cpu_req holds cpu_addr/cpu_data stable until the single-cycle
   // cpu_ack; the request is consumed in the ack cycle and no new request is
   // granted in the cycle right after an ack.
   logic                     cpu_req;
   logic [TADDRW-1:0]        cpu_addr;
   logic [7:0]               cpu_data;
   logic                     cpu_ack;
   logic                     busy;
   logic                     overrun;

   modport master (
      input  line, sy, tram_rdata, font_bits, cpu_req, cpu_addr, cpu_data,
      output tram_addr, tram_rd, tram_wr, tram_wdata, font_char, font_row,
             lb_we, lb_bank, lb_addr, lb_data, disp_bank, cpu_ack, busy, overrun
   );

   modport slave (
      output line, sy, tram_rdata, font_bits, cpu_req, cpu_addr, cpu_data,
      input  tram_addr, tram_rd, tram_wr, tram_wdata, font_char, font_row,
             lb_we, lb_bank, lb_addr, lb_data, disp_bank, cpu_ack, busy, overrun
   );
endinterface

// File: rtl/text_fetch_sched.sv
// Prefetches the next display line's glyph row bits into a double-buffered line
// buffer: text RAM code -> font ROM row -> line buffer, one column per cycle.
module text_fetch_sched #(
   parameter int CORDW    = 11,
   parameter int COLS     = 64,
   parameter int ROWS     = 18,
   parameter int SCALE_SH = 1
) (
   input  logic               clk_pix,
   input  logic               rst_pix,
   text_fetch_sched_if.master bus,
   output logic [1:0]         fsm_state
);
   localparam int TADDRW = $clog2(COLS * ROWS);
   localparam int CADDRW = $clog2(COLS);
   localparam logic signed [CORDW:0] LINES_W = (CORDW+1)'(ROWS * (8 << SCALE_SH));
   localparam logic [TADDRW:0]       TEXT_N  = (TADDRW+1)'(COLS * ROWS);
   localparam logic [CADDRW-1:0]     COL_MAX = CADDRW'(COLS - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [CADDRW-1:0]   col_q, col_d;
   logic                drain_q, drain_d;
   logic                issue;
   logic                fetch_ok_q, disp_q, lbbank_q, cpu_hold_q;
   logic [2:0]          row_q;
   logic [TADDRW-1:0]   base_q;
   logic                s1_v, s1_ok, s2_v, s2_ok;
   logic [CADDRW-1:0]   s1_col, s2_col;
   logic [2:0]          s1_row;
   logic signed [CORDW:0] t;
   logic [CORDW:0]      g;
   logic                t_ok;
   logic [TADDRW-1:0]   tr_base;
   logic                grant;

   // Target line is sy+1; negative sy is always blank even though sy=-1 gives T=0.
   assign t       = $signed({bus.sy[CORDW-1], bus.sy}) + (CORDW+1)'(1);
   assign t_ok    = !bus.sy[CORDW-1] && (t < LINES_W);
   assign g       = (CORDW+1)'(t) >> SCALE_SH;
   assign tr_base = TADDRW'(int'(g >> 3) * COLS);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      drain_d = drain_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: ;
         READ: begin
            issue = !bus.line;
            if (col_q == COL_MAX) begin
               state_d = DRAIN;
               drain_d = 1'b0;
            end else begin
               col_d = col_q + CADDRW'(1);
            end
         end
         DRAIN: begin
            if (drain_q) state_d = IDLE;
            else         drain_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (bus.line) begin
         state_d = READ;
         col_d   = '0;
      end
   end

   always_comb begin
      bus.tram_rd    = issue && fetch_ok_q;
      grant          = bus.cpu_req && !cpu_hold_q && !bus.tram_rd && !rst_pix;
      bus.tram_wr    = grant && ({1'b0, bus.cpu_addr} < TEXT_N);
      bus.tram_addr  = '0;
      if (bus.tram_rd)      bus.tram_addr = base_q + TADDRW'(col_q);
      else if (bus.tram_wr) bus.tram_addr = bus.cpu_addr;
      bus.tram_wdata = bus.tram_wr ? bus.cpu_data : 8'h00;
      bus.cpu_ack    = grant;
      bus.font_char  = (s1_v && s1_ok) ? bus.tram_rdata : 8'h00;
      bus.font_row   = s1_v ? s1_row : 3'd0;
      bus.lb_we      = s2_v;
      bus.lb_addr    = s2_v ? s2_col : '0;
      bus.lb_data    = (s2_v && s2_ok) ? bus.font_bits : 8'h00;
      bus.lb_bank    = lbbank_q;
      bus.disp_bank  = disp_q;
      bus.busy       = (state_q != IDLE);
      bus.overrun    = bus.line && (state_q != IDLE);
   end

   assign fsm_state = state_q;

   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state_q    <= IDLE;
         col_q      <= '0;
         drain_q    <= 1'b0;
         fetch_ok_q <= 1'b0;
         row_q      <= 3'd0;
         base_q     <= '0;
         disp_q     <= 1'b0;
         lbbank_q   <= 1'b0;
         cpu_hold_q <= 1'b1;
         s1_v       <= 1'b0;
         s1_ok      <= 1'b0;
         s1_col     <= '0;
         s1_row     <= 3'd0;
         s2_v       <= 1'b0;
         s2_ok      <= 1'b0;
         s2_col     <= '0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         drain_q    <= drain_d;
         cpu_hold_q <= grant;
         if (bus.line) begin
            disp_q     <= ~disp_q;
            lbbank_q   <= ~disp_q;
            fetch_ok_q <= t_ok;
            row_q      <= g[2:0];
            base_q     <= tr_base;
         end
         s1_v   <= issue;
         s1_ok  <= fetch_ok_q;
         s1_col <= col_q;
         s1_row <= row_q;
         // A new line squashes the column still waiting on the font ROM.
         s2_v   <= s1_v && !bus.line;
         s2_ok  <= s1_ok;
         s2_col <= s1_col;
      end
   end
endmodule

// File: tb/tb_text_fetch_sched.sv
// Directed bench for text_fetch_sched with text RAM / font ROM models and
// per-run logs compared against hand-derived expectations.
module tb_text_fetch_sched;
   localparam int NTEXT = 64 * 18;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] fsm_state;
   logic       mem_init = 1'b1;
   logic [7:0] mem     [0:NTEXT-1];
   logic [7:0] ref_mem [0:NTEXT-1];
   int         checks = 0;
   int         errors = 0;

   text_fetch_sched_if #(.CORDW(11), .COLS(64), .ROWS(18)) bus ();

   text_fetch_sched #(.CORDW(11), .COLS(64), .ROWS(18), .SCALE_SH(1)) dut (
      .clk_pix   (clk),
      .rst_pix   (rst),
      .bus       (bus.master),
      .fsm_state (fsm_state)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] font_fn(input logic [7:0] ch, input logic [2:0] row);
      return {ch[4:0], row} ^ {row, ch[7:3]} ^ 8'hA5;
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < NTEXT; i++) mem[i] <= 8'(i ^ 'h3C);
      end else begin
         if (bus.tram_rd && int'(bus.tram_addr) < NTEXT) bus.tram_rdata <= mem[bus.tram_addr];
         if (bus.tram_wr && int'(bus.tram_addr) < NTEXT) mem[bus.tram_addr] <= bus.tram_wdata;
      end
      bus.font_bits <= font_fn(bus.font_char, bus.font_row);
   end

   int o_rd_rel[$], o_rd_addr[$], o_we_rel[$], o_we_addr[$], o_we_data[$];
   int o_ack[$], o_ovr[$], o_disp[$], o_lbb[$], o_busy[$], o_frow[$];
   int e_rd_rel[$], e_rd_addr[$], e_we_rel[$], e_we_addr[$], e_we_data[$];
   int e_ack[$], e_ovr[$];
   int wr_n;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tram_addr"}, int'(bus.tram_addr), 0);
      check({tag, "_tram_rd"}, int'(bus.tram_rd), 0);
      check({tag, "_tram_wr"}, int'(bus.tram_wr), 0);
      check({tag, "_tram_wdata"}, int'(bus.tram_wdata), 0);
      check({tag, "_font_char"}, int'(bus.font_char), 0);
      check({tag, "_font_row"}, int'(bus.font_row), 0);
      check({tag, "_lb_we"}, int'(bus.lb_we), 0);
      check({tag, "_lb_bank"}, int'(bus.lb_bank), 0);
      check({tag, "_lb_addr"}, int'(bus.lb_addr), 0);
      check({tag, "_lb_data"}, int'(bus.lb_data), 0);
      check({tag, "_disp_bank"}, int'(bus.disp_bank), 0);
      check({tag, "_cpu_ack"}, int'(bus.cpu_ack), 0);
      check({tag, "_busy"}, int'(bus.busy), 0);
      check({tag, "_overrun"}, int'(bus.overrun), 0);
      check({tag, "_fsm"}, int'(fsm_state), 0);
   endtask

   task automatic clear_exp();
      e_rd_rel.delete(); e_rd_addr.delete(); e_we_rel.delete(); e_we_addr.delete();
      e_we_data.delete(); e_ack.delete(); e_ovr.delete();
   endtask

   // Expected reads/writes of one fetch started by a pulse at rel p.
   task automatic add_fetch(input int p, input int sy, input int nrd, input int nwe);
      int t, g, tr, row;
      bit ok;
      t   = sy + 1;
      ok  = (sy >= 0) && (t < 18 * 16);
      g   = t >>> 1;
      tr  = g / 8;
      row = g % 8;
      for (int c = 0; c < 64; c++) begin
         if (ok && c < nrd) begin
            e_rd_rel.push_back(p + 1 + c);
            e_rd_addr.push_back(tr * 64 + c);
         end
         if (c < nwe) begin
            e_we_rel.push_back(p + 3 + c);
            e_we_addr.push_back(c);
            e_we_data.push_back(ok ? int'(font_fn(ref_mem[tr * 64 + c], 3'(row))) : 0);
         end
      end
   endtask

   task automatic run(input int p1, input int sy0, input int p2, input int sy1,
                      input int rst_at, input int cpu_start, input int ncpu,
                      input int cpu_base, input int ncyc);
      int idx;
      logic [10:0] ca;
      logic [7:0]  cd;
      idx = 0; ca = '0; cd = '0; wr_n = 0;
      o_rd_rel.delete(); o_rd_addr.delete(); o_we_rel.delete(); o_we_addr.delete();
      o_we_data.delete(); o_ack.delete(); o_ovr.delete(); o_disp.delete();
      o_lbb.delete(); o_busy.delete(); o_frow.delete();
      for (int rel = 0; rel < ncyc; rel++) begin
         @(posedge clk); #1;
         bus.line = (rel == p1) || (rel == p2);
         bus.sy   = (rel == p2) ? sy1[10:0] : sy0[10:0];
         rst      = (rel == rst_at);
         if (rel >= cpu_start && idx < ncpu) begin
            ca = 11'(cpu_base + idx * 37);
            cd = 8'(idx * 29 + 7);
            bus.cpu_req = 1'b1; bus.cpu_addr = ca; bus.cpu_data = cd;
         end else begin
            bus.cpu_req = 1'b0;
         end
         @(negedge clk);
         if (rst_at >= 0 && rel == rst_at + 1) check_all_zero("after_rst");
         check("rd_wr_excl", int'(bus.tram_rd & bus.tram_wr), 0);
         if (bus.tram_rd) begin
            o_rd_rel.push_back(rel); o_rd_addr.push_back(int'(bus.tram_addr));
         end
         if (bus.lb_we) begin
            o_we_rel.push_back(rel); o_we_addr.push_back(int'(bus.lb_addr));
            o_we_data.push_back(int'(bus.lb_data));
         end
         if (bus.overrun) o_ovr.push_back(rel);
         o_disp.push_back(int'(bus.disp_bank));
         o_lbb.push_back(int'(bus.lb_bank));
         o_busy.push_back(int'(bus.busy));
         o_frow.push_back(int'(bus.font_row));
         if (bus.tram_wr) begin
            wr_n++;
            check("wr_addr", int'(bus.tram_addr), int'(ca));
            check("wr_data", int'(bus.tram_wdata), int'(cd));
         end
         if (bus.cpu_ack) begin
            o_ack.push_back(rel);
            if (int'(ca) < NTEXT) ref_mem[ca] = cd;
            idx++;
         end
      end
      bus.line = 1'b0; bus.cpu_req = 1'b0; rst = 1'b0;
   endtask

   task automatic verify(input string tn, input int busy_n);
      int n, s;
      check({tn, "_rd_n"}, o_rd_rel.size(), e_rd_rel.size());
      n = (o_rd_rel.size() < e_rd_rel.size()) ? o_rd_rel.size() : e_rd_rel.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_rd_rel[%0d]", tn, i), o_rd_rel[i], e_rd_rel[i]);
         check($sformatf("%s_rd_addr[%0d]", tn, i), o_rd_addr[i], e_rd_addr[i]);
      end
      check({tn, "_we_n"}, o_we_rel.size(), e_we_rel.size());
      n = (o_we_rel.size() < e_we_rel.size()) ? o_we_rel.size() : e_we_rel.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_we_rel[%0d]", tn, i), o_we_rel[i], e_we_rel[i]);
         check($sformatf("%s_we_addr[%0d]", tn, i), o_we_addr[i], e_we_addr[i]);
         check($sformatf("%s_we_data[%0d]", tn, i), o_we_data[i], e_we_data[i]);
      end
      check({tn, "_ack_n"}, o_ack.size(), e_ack.size());
      n = (o_ack.size() < e_ack.size()) ? o_ack.size() : e_ack.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_ack[%0d]", tn, i), o_ack[i], e_ack[i]);
      check({tn, "_ovr_n"}, o_ovr.size(), e_ovr.size());
      n = (o_ovr.size() < e_ovr.size()) ? o_ovr.size() : e_ovr.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_ovr[%0d]", tn, i), o_ovr[i], e_ovr[i]);
      s = 0;
      foreach (o_busy[i]) s += o_busy[i];
      check({tn, "_busy_n"}, s, busy_n);
      check({tn, "_busy_rel1"}, o_busy[1], 1);
      check({tn, "_busy_rel0"}, o_busy[0], 0);
   endtask

   task automatic check_bank(input string tn, input int rel, input int disp, input int lbb);
      check({tn, "_disp_bank"}, o_disp[rel], disp);
      check({tn, "_lb_bank"}, o_lbb[rel], lbb);
   endtask

   initial begin
      int bad;
      bus.line = 1'b0; bus.sy = '0; bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
      for (int i = 0; i < NTEXT; i++) ref_mem[i] = 8'(i ^ 'h3C);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0; mem_init = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      repeat (3) @(posedge clk);

      // sy=15: T=16 -> row 1 of text (addr 64..127), glyph row 0.
      clear_exp();
      run(0, 15, -1, 0, -1, 0, 0, 0, 72);
      add_fetch(0, 15, 64, 64);
      verify("t1", 66);
      check_bank("t1", 1, 1, 1);
      check("t1_disp_rel0", o_disp[0], 0);
      check("t1_frow", o_frow[2], 0);

      clear_exp();
      run(0, 47, -1, 0, -1, 0, 0, 0, 72);
      add_fetch(0, 47, 64, 64);
      verify("t2a", 66);
      check_bank("t2a", 1, 0, 0);
      check("t2a_frow", o_frow[2], 0);

      clear_exp();
      run(0, 46, -1, 0, -1, 0, 0, 0, 72);
      add_fetch(0, 46, 64, 64);
      verify("t2b", 66);
      check_bank("t2b", 1, 1, 1);
      check("t2b_frow", o_frow[2], 7);

      // CPU held across a fetch: acked in the pulse cycle, then after the reads.
      clear_exp();
      e_ack = '{0, 65, 67, 69};
      run(0, 15, -1, 0, -1, 0, 4, 500, 80);
      add_fetch(0, 15, 64, 64);
      verify("t3", 66);
      check_bank("t3", 1, 0, 0);
      check("t3_wr_n", wr_n, 4);

      clear_exp();
      e_ack = '{0, 2, 4, 6, 8, 10};
      run(0, -1, -1, 0, -1, 0, 6, 700, 72);
      add_fetch(0, -1, 64, 64);
      verify("t4a", 66);
      check_bank("t4a", 1, 1, 1);
      check("t4a_wr_n", wr_n, 6);

      clear_exp();
      run(0, 287, -1, 0, -1, 0, 0, 0, 72);
      add_fetch(0, 287, 64, 64);
      verify("t4b", 66);
      check_bank("t4b", 1, 0, 0);

      // Second pulse at rel 20: old fetch loses cols >= 18, new fetch runs in full.
      clear_exp();
      e_ovr = '{20};
      run(0, 15, 20, 47, -1, 0, 0, 0, 92);
      add_fetch(0, 15, 19, 18);
      add_fetch(20, 47, 64, 64);
      verify("t5", 86);
      check_bank("t5a", 1, 1, 1);
      check_bank("t5b", 21, 0, 0);

      // Reset at rel 10; out-of-range CPU write acked without a RAM write.
      clear_exp();
      e_ack = '{12};
      run(0, 15, -1, 0, 10, 10, 1, NTEXT, 16);
      add_fetch(0, 15, 10, 8);
      verify("t6", 10);
      check("t6_wr_n", wr_n, 0);
      check("t6_disp_after", o_disp[11], 0);

      repeat (2) @(posedge clk);
      bad = 0;
      for (int i = 0; i < NTEXT; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_contents", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
